// File: rtl/fa_using_ha.sv
// rtl/fa_using_ha.sv - 1-bit full adder from two half adders, with optional output register

// Half adder leaf: sum and carry of two bits
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic co
);

    // Sum is the parity of the two bits; carry is set only when both are set
    assign s  = x ^ y;
    assign co = x & y;

endmodule

// Full adder built structurally; sumf/carryf are combinational, sum_q/carry_q registered
module fa_using_ha #(
    parameter bit REG_OUT = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sumf,
    output logic carryf,
    output logic sum_q,
    output logic carry_q
);

    logic s1;
    logic c1;
    logic c2;

    // First stage adds the two addends
    half_adder u_ha1 (
        .x  (a),
        .y  (b),
        .s  (s1),
        .co (c1)
    );

    // Second stage folds in the carry-in
    half_adder u_ha2 (
        .x  (s1),
        .y  (c),
        .s  (sumf),
        .co (c2)
    );

    // At most one stage can generate a carry, so OR merges them
    assign carryf = c1 | c2;

    generate
        if (REG_OUT) begin : g_reg
            // Capture the combinational result every cycle; reset clears asynchronously
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_q   <= 1'b0;
                    carry_q <= 1'b0;
                end else begin
                    sum_q   <= sumf;
                    carry_q <= carryf;
                end
            end
        end else begin : g_noreg
            // Registered outputs are tied off; clock and reset are intentionally sunk
            logic unused_clk_rst;
            assign unused_clk_rst = clk & rst_n;
            assign sum_q          = 1'b0;
            assign carry_q        = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_fa_using_ha.sv
// tb/tb_fa_using_ha.sv - randomized self-checking bench for fa_using_ha

module tb_fa_using_ha;

    logic clk;
    logic rst_n;
    logic a;
    logic b;
    logic c;
    logic sumf;
    logic carryf;
    logic sum_q;
    logic carry_q;
    logic sumf_nr;
    logic carryf_nr;
    logic sum_q_nr;
    logic carry_q_nr;

    int n_compared;
    int n_mismatched;

    fa_using_ha #(.REG_OUT(1'b1)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .c       (c),
        .sumf    (sumf),
        .carryf  (carryf),
        .sum_q   (sum_q),
        .carry_q (carry_q)
    );

    fa_using_ha #(.REG_OUT(1'b0)) u_dut_noreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .c       (c),
        .sumf    (sumf_nr),
        .carryf  (carryf_nr),
        .sum_q   (sum_q_nr),
        .carry_q (carry_q_nr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: the two-bit arithmetic count of set inputs
    function automatic logic [1:0] ref_add(input logic ra, input logic rb, input logic rc);
        int total;
        total = int'(ra) + int'(rb) + int'(rc);
        return total[1:0];
    endfunction

    // Drive inputs after a falling edge, check both paths of both builds
    task automatic step(input logic va, input logic vb, input logic vc);
        logic [1:0] exp;
        @(negedge clk);
        a = va;
        b = vb;
        c = vc;
        exp = ref_add(va, vb, vc);
        #1;
        check("comb", {carryf, sumf}, exp);
        check("comb_noreg", {carryf_nr, sumf_nr}, exp);
        @(posedge clk);
        #1;
        check("reg", {carry_q, sum_q}, exp);
        check("reg_noreg", {carry_q_nr, sum_q_nr}, 2'b00);
    endtask

    initial begin
        logic [2:0] v;
        clk = 1'b0;
        rst_n = 1'b0;
        a = 1'b0;
        b = 1'b0;
        c = 1'b0;
        n_compared = 0;
        n_mismatched = 0;

        // Reset state, including across clock edges while held
        #1;
        check("reset_q", {carry_q, sum_q}, 2'b00);
        @(posedge clk);
        #1;
        check("reset_q_hold", {carry_q, sum_q}, 2'b00);

        // Clock-free exhaustive sweep of the combinational path while in reset
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {a, b, c} = v;
            #1;
            check("sweep", {carryf, sumf}, ref_add(v[2], v[1], v[0]));
            check("sweep_q_in_reset", {carry_q, sum_q}, 2'b00);
        end

        // Release and first load
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);

        // Reset mid-run, between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_q", {carry_q, sum_q}, 2'b00);
        check("midrst_comb", {carryf, sumf}, 2'b11);
        @(posedge clk);
        #1;
        check("midrst_q_hold", {carry_q, sum_q}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        // Corners, then exhaustive with clocking, then random
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            step(v[2], v[1], v[0]);
        end
        for (int i = 0; i < 100; i++) begin
            v = 3'($urandom_range(7, 0));
            step(v[2], v[1], v[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
